// File: rtl/regfile_scoreboard.sv
// Register file with a busy scoreboard for the decode stage.
// Latency: reads are combinational (0 cycles); the write, busy bits and count update on posedge clk.
// Backpressure: none; rs_busy_o tells the hazard unit when a consumer has to stall.
//
// Ports:
//   clk, rst          - clock; asynchronous active-high reset (clears data, busy bits, count)
//   global_flush_i    - clears every busy bit; register data is left alone
//   rs_addr_i         - NUM_RD_PORTS packed read addresses, port k at [k*AW +: AW]
//   rs_data_o         - packed read data, port k at [k*XLEN +: XLEN]
//   rs_busy_o         - per-port hazard flag
//   rd_addr_i, write_data_i, reg_write_en - writeback port
//   issue_en_i, issue_rd_i                - destination of the instruction issued this cycle
//   busy_count_o      - registered number of busy registers
//   rs_dbg_addr_i, rs_dbg_data_o          - committed-state debug read, only with REGFILE_DBG_PORT_EN
//
// Build option: define REGFILE_DBG_PORT_EN to add the debug read port.
module regfile_scoreboard #(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int ZERO_REG     = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   global_flush_i,
    input  logic [NUM_RD_PORTS*$clog2(NREGS)-1:0]  rs_addr_i,
    output logic [NUM_RD_PORTS*XLEN-1:0]           rs_data_o,
    output logic [NUM_RD_PORTS-1:0]                rs_busy_o,
    input  logic [$clog2(NREGS)-1:0]               rd_addr_i,
    input  logic [XLEN-1:0]                        write_data_i,
    input  logic                                   reg_write_en,
    input  logic                                   issue_en_i,
    input  logic [$clog2(NREGS)-1:0]               issue_rd_i,
    output logic [$clog2(NREGS+1)-1:0]             busy_count_o
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [$clog2(NREGS)-1:0]               rs_dbg_addr_i,
    output logic [XLEN-1:0]                        rs_dbg_data_o
`endif
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    count_nxt;
    logic             wr_ok;
    logic             issue_ok;

    // Register 0 swallows writes and issues when it is hardwired to zero.
    assign wr_ok    = reg_write_en && ((ZERO_REG == 0) || (rd_addr_i != '0));
    assign issue_ok = issue_en_i   && ((ZERO_REG == 0) || (issue_rd_i != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            // A flush does not block the write: the producer already completed.
            regs[rd_addr_i] <= write_data_i;
        end
    end

    // Per-register priority: flush, then issue (newer producer wins over a
    // same-cycle writeback of the older one), then writeback clear.
    always_comb begin
        busy_nxt  = busy;
        count_nxt = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (global_flush_i) begin
                busy_nxt[r] = 1'b0;
            end else if (issue_ok && (issue_rd_i == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (reg_write_en && (rd_addr_i == AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end
            count_nxt = count_nxt + CW'(busy_nxt[r]);
        end
    end

    // The count is a popcount of the next bits so it lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            busy_count_o <= '0;
        end else begin
            busy         <= busy_nxt;
            busy_count_o <= count_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          fwd_hit;

        assign addr    = rs_addr_i[k*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        // Forwarding is gated by rst so every read port shows 0 while reset is held.
        assign fwd_hit = wr_ok && !rst && (rd_addr_i == addr);

        assign rs_data_o[k*XLEN +: XLEN] = is_zero ? '0 :
                                           fwd_hit ? write_data_i : regs[addr];
        // A writeback in this very cycle resolves the hazard through forwarding.
        assign rs_busy_o[k] = busy[addr] && !(reg_write_en && (rd_addr_i == addr));
    end

`ifdef REGFILE_DBG_PORT_EN
    // Committed state only: no forwarding, no scoreboard interaction.
    assign rs_dbg_data_o = regs[rs_dbg_addr_i];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard with a behavioural reference model.
// Latency: outputs sampled at negedge; model state advances on each posedge.
// Backpressure: not applicable; directed steps followed by a random phase.
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NP    = 2;
    localparam int AW    = $clog2(NREGS);
    localparam int CW    = $clog2(NREGS + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [NP*AW-1:0]     rs_addr;
    logic [NP*XLEN-1:0]   rs_data;
    logic [NP-1:0]        rs_busy;
    logic [AW-1:0]        rd_addr;
    logic [XLEN-1:0]      wdata;
    logic                 we;
    logic                 issue_en;
    logic [AW-1:0]        issue_rd;
    logic [CW-1:0]        busy_count;
`ifdef REGFILE_DBG_PORT_EN
    logic [AW-1:0]        dbg_addr;
    logic [XLEN-1:0]      dbg_data;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: architectural contents and the set of in-flight destinations.
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NUM_RD_PORTS(NP), .ZERO_REG(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .global_flush_i(flush),
        .rs_addr_i     (rs_addr),
        .rs_data_o     (rs_data),
        .rs_busy_o     (rs_busy),
        .rd_addr_i     (rd_addr),
        .write_data_i  (wdata),
        .reg_write_en  (we),
        .issue_en_i    (issue_en),
        .issue_rd_i    (issue_rd),
        .busy_count_o  (busy_count)
`ifdef REGFILE_DBG_PORT_EN
        ,
        .rs_dbg_addr_i (dbg_addr),
        .rs_dbg_data_o (dbg_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < NREGS; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (rst || a == 0) return '0;
        if (we && int'(rd_addr) == a) return wdata;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (rst) return 1'b0;
        return m_busy[a] && !(we && int'(rd_addr) == a);
    endfunction

    function automatic int port_addr(input int k);
        return int'(rs_addr[k*AW +: AW]);
    endfunction

    function automatic logic [XLEN-1:0] port_data(input int k);
        return rs_data[k*XLEN +: XLEN];
    endfunction

    task automatic set_port(input int k, input int a);
        rs_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic idle();
        we = 1'b0; issue_en = 1'b0; flush = 1'b0;
        rd_addr = '0; issue_rd = '0; wdata = '0;
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NP; k++) begin
            chk($sformatf("data_p%0d_a%0d", k, port_addr(k)), port_data(k), exp_data(port_addr(k)));
            chk($sformatf("busy_p%0d_a%0d", k, port_addr(k)), 32'(rs_busy[k]), 32'(exp_busy(port_addr(k))));
        end
        chk("busy_count", 32'(busy_count), rst ? 32'd0 : 32'(m_count()));
`ifdef REGFILE_DBG_PORT_EN
        chk("dbg_data", dbg_data, rst ? 32'd0 : m_reg[dbg_addr]);
`endif
    endtask

    // Advance the model by the rules for one clock edge with the current inputs.
    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else begin
            if (we && rd_addr != 0) m_reg[rd_addr] = wdata;
            if (flush) begin
                for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
            end else begin
                if (we) m_busy[rd_addr] = 1'b0;
                if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        settle();
        clock_edge();
    endtask

    initial begin
        model_clear();
        rst = 1'b1;
        idle();
        rs_addr = '0;
`ifdef REGFILE_DBG_PORT_EN
        dbg_addr = '0;
`endif
        // Reset held for two cycles with random traffic on every input.
        for (int i = 0; i < 2; i++) begin
            rs_addr  = NP*AW'($urandom);
            we       = 1'($urandom);
            rd_addr  = AW'($urandom);
            wdata    = $urandom;
            issue_en = 1'($urandom);
            issue_rd = AW'($urandom);
            settle();
            chk("rst_data_p0", port_data(0), 32'd0);
            chk("rst_busy", 32'(rs_busy), 32'd0);
            chk("rst_count", 32'(busy_count), 32'd0);
            clock_edge();
        end
        rst = 1'b0;
        idle();

        // Write x1, read it back next cycle.
        we = 1'b1; rd_addr = 5'd1; wdata = 32'hDEADBEEF; set_port(0, 1);
        step();
        idle();
        settle();
        chk("x1_read", port_data(0), 32'hDEADBEEF);
        clock_edge();

        // Same-cycle forwarding on port 1.
        we = 1'b1; rd_addr = 5'd2; wdata = 32'hCAFEBABE; set_port(1, 2);
        settle();
        chk("fwd_x2", port_data(1), 32'hCAFEBABE);
        clock_edge();
        idle();

        // x0 invariant.
        issue_en = 1'b1; issue_rd = 5'd0;
        step();
        idle();
        we = 1'b1; rd_addr = 5'd0; wdata = 32'hFFFFFFFF; set_port(0, 0);
        settle();
        chk("x0_fwd", port_data(0), 32'd0);
        clock_edge();
        idle();
        settle();
        chk("x0_data", port_data(0), 32'd0);
        chk("x0_busy", 32'(rs_busy[0]), 32'd0);
        chk("x0_count", 32'(busy_count), 32'd0);
        clock_edge();

        // Scoreboard set and writeback clear.
        issue_en = 1'b1; issue_rd = 5'd5;
        step();
        idle();
        set_port(0, 5);
        settle();
        chk("x5_busy", 32'(rs_busy[0]), 32'd1);
        chk("x5_count", 32'(busy_count), 32'd1);
        clock_edge();
        we = 1'b1; rd_addr = 5'd5; wdata = 32'h12345678;
        settle();
        chk("x5_wb_busy", 32'(rs_busy[0]), 32'd0);
        chk("x5_wb_data", port_data(0), 32'h12345678);
        clock_edge();
        idle();
        settle();
        chk("x5_wb_count", 32'(busy_count), 32'd0);
        clock_edge();

        // Issue/writeback collision, then flush (with a concurrent issue).
        issue_en = 1'b1; issue_rd = 5'd7; we = 1'b1; rd_addr = 5'd7; wdata = 32'hA5A5A5A5;
        step();
        idle();
        set_port(0, 7);
        settle();
        chk("x7_data", port_data(0), 32'hA5A5A5A5);
        chk("x7_busy", 32'(rs_busy[0]), 32'd1);
        clock_edge();
        issue_en = 1'b1; issue_rd = 5'd3;
        step();
        issue_rd = 5'd4;
        step();
        idle();
        settle();
        chk("pre_flush_count", 32'(busy_count), 32'd3);
        clock_edge();
        flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd6; we = 1'b1; rd_addr = 5'd8; wdata = 32'h0000_0808;
        step();
        idle();
        set_port(1, 8);
        settle();
        chk("flush_count", 32'(busy_count), 32'd0);
        chk("flush_x7_data", port_data(0), 32'hA5A5A5A5);
        chk("flush_x7_busy", 32'(rs_busy[0]), 32'd0);
        chk("flush_cycle_write", port_data(1), 32'h0000_0808);
        clock_edge();

`ifdef REGFILE_DBG_PORT_EN
        // Debug port shows committed state, not the pending write.
        we = 1'b1; rd_addr = 5'd9; wdata = 32'h0BADF00D;
        step();
        we = 1'b1; rd_addr = 5'd9; wdata = 32'h600DCAFE; dbg_addr = 5'd9;
        settle();
        chk("dbg_old", dbg_data, 32'h0BADF00D);
        clock_edge();
        idle();
        settle();
        chk("dbg_new", dbg_data, 32'h600DCAFE);
        clock_edge();
`endif

        // Random phase: narrow address range to provoke collisions and forwarding.
        for (int i = 0; i < 400; i++) begin
            we       = ($urandom_range(0, 1) == 1);
            rd_addr  = AW'($urandom_range(0, 11));
            wdata    = $urandom;
            issue_en = ($urandom_range(0, 2) != 0);
            issue_rd = AW'($urandom_range(0, 11));
            flush    = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NP; k++) set_port(k, $urandom_range(0, 11));
`ifdef REGFILE_DBG_PORT_EN
            dbg_addr = AW'($urandom_range(0, 11));
`endif
            step();
        end

        // Asynchronous mid-cycle reset after writes and an issue.
        idle();
        we = 1'b1; rd_addr = 5'd10; wdata = 32'h1111_2222;
        step();
        idle();
        issue_en = 1'b1; issue_rd = 5'd11;
        step();
        idle();
        set_port(0, 10); set_port(1, 11);
        settle();
        chk("pre_rst_x10", port_data(0), 32'h1111_2222);
        chk("pre_rst_busy11", 32'(rs_busy[1]), 32'd1);
        @(posedge clk);
        model_edge();
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_data", port_data(0), 32'd0);
        chk("async_rst_busy", 32'(rs_busy), 32'd0);
        chk("async_rst_count", 32'(busy_count), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        chk("post_rst_x10", port_data(0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
